// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and legality check.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  // Legal opcodes occupy the contiguous range ADD..XOR
  function automatic logic op_legal(input logic [3:0] opcode);
    return (opcode <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the scan starts just above the last
// winner and wraps, so the previous winner has the lowest priority.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic [IW-1:0] idx;
  logic          found;

  // First requester found scanning upward from last+1 wins
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one pipelined ALU between NREQ requesters. Issue is arbitrated
// round-robin; a tag pipeline matched to the ALU latency steers each
// result back to the requester that issued it.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_opcode,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  output logic              resp_err,
  output logic [3:0]        alu_opcode,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] gnt;
  logic            accept;
  logic [IW-1:0]   win_idx;
  logic [3:0]      win_op;
  logic [W-1:0]    win_a;
  logic [W-1:0]    win_b;
  logic            win_legal;

  logic            tag_v   [LAT];
  logic [IW-1:0]   tag_idx [LAT];
  logic            tag_err [LAT];
  logic [NREQ-1:0] tag_onehot;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  // No grant may be given while reset is held
  assign req_ready = rst ? gnt : '0;
  assign accept    = |req_ready;

  // Select the winning requester's index and operands
  always_comb begin
    win_idx = '0;
    win_op  = OP_ADD;
    win_a   = '0;
    win_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_idx = IW'(i);
        win_op  = req_opcode[4*i +: 4];
        win_a   = req_a[W*i +: W];
        win_b   = req_b[W*i +: W];
      end
    end
  end

  assign win_legal = op_legal(win_op);

  // Illegal or absent operations send a harmless ADD 0+0 to the ALU
  always_comb begin
    alu_opcode = OP_ADD;
    alu_a      = '0;
    alu_b      = '0;
    if (accept && win_legal) begin
      alu_opcode = win_op;
      alu_a      = win_a;
      alu_b      = win_b;
    end
  end

  // Round-robin pointer; reset value gives requester 0 first priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IW'(NREQ - 1);
    end else if (accept) begin
      last_grant <= win_idx;
    end
  end

  // Tag shift register runs in lockstep with the ALU pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LAT; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
        tag_err[s] <= 1'b0;
      end
    end else begin
      tag_v[0]   <= accept;
      tag_idx[0] <= win_idx;
      tag_err[0] <= accept & ~win_legal;
      for (int s = 1; s < LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
        tag_err[s] <= tag_err[s-1];
      end
    end
  end

  assign tag_onehot = NREQ'(1) << tag_idx[LAT-1];

  // Register the result and steer its strobe to the tagged requester
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (tag_v[LAT-1]) begin
      resp_valid <= tag_onehot;
      resp_data  <= tag_err[LAT-1] ? '0 : alu_result;
      resp_err   <= tag_err[LAT-1];
    end else begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU in the environment, a reference
// model of requesters, round-robin grants and a queue of expected responses.
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_opcode;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic [3:0]        alu_opcode;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [W-1:0]      alu_result;

  alu_scheduler #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input logic [3:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      OP_ADD:  return W'(a + b);
      OP_SUB:  return W'(a - b);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Environment ALU: result of cycle-c operands appears in cycle c+LAT
  logic [W-1:0] alu_pipe [LAT];
  initial for (int s = 0; s < LAT; s++) alu_pipe[s] = '0;
  always @(posedge clk) begin
    alu_pipe[0] <= ref_result(alu_opcode, alu_a, alu_b);
    for (int s = 1; s < LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
  end
  assign alu_result = alu_pipe[LAT-1];

  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  rsp_t         q[$];
  bit           pv  [NREQ];
  logic [3:0]   pop [NREQ];
  logic [W-1:0] pa  [NREQ];
  logic [W-1:0] pb  [NREQ];
  int           last;
  int           cyc;
  int           passed;
  int           total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    pv[i]  = 1'b1;
    pop[i] = op;
    pa[i]  = a;
    pb[i]  = b;
  endtask

  // Idle requesters present random junk that must be ignored
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pv[i];
      req_opcode[4*i +: 4] = pv[i] ? pop[i] : 4'($urandom);
      req_a[W*i +: W]     = pv[i] ? pa[i] : W'($urandom);
      req_b[W*i +: W]     = pv[i] ? pb[i] : W'($urandom);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
  endtask

  // One clock cycle: predict, check mid-cycle, then advance the model
  task automatic step();
    int              win;
    int              cand;
    logic [NREQ-1:0] er;
    logic [3:0]      eop;
    logic [W-1:0]    ea;
    logic [W-1:0]    eb;
    logic [NREQ-1:0] erv;
    logic [W-1:0]    ed;
    logic            ee;
    bit              due_now;
    rsp_t            r;
    drive();
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (last + k) % NREQ;
      if (win < 0 && pv[cand]) win = cand;
    end
    er = '0; eop = 4'd0; ea = '0; eb = '0;
    if (win >= 0) begin
      er[win] = 1'b1;
      if (pop[win] <= 4'd4) begin
        eop = pop[win]; ea = pa[win]; eb = pb[win];
      end
    end
    due_now = (q.size() > 0) && (q[0].due == cyc);
    erv = '0; ed = '0; ee = 1'b0;
    if (due_now) begin
      erv[q[0].idx] = 1'b1;
      ed = q[0].data;
      ee = q[0].err;
    end
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("alu_opcode", 32'(alu_opcode), 32'(eop));
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("resp_valid", 32'(resp_valid), 32'(erv));
    chk("resp_data", 32'(resp_data), 32'(ed));
    chk("resp_err", 32'(resp_err), 32'(ee));
    @(posedge clk);
    #1;
    if (due_now) void'(q.pop_front());
    if (win >= 0) begin
      r.due  = cyc + LAT + 1;
      r.idx  = win;
      r.err  = (pop[win] > 4'd4);
      r.data = r.err ? '0 : ref_result(pop[win], pa[win], pb[win]);
      q.push_back(r);
      last    = win;
      pv[win] = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain();
    bit busy;
    for (int n = 0; n < 40; n++) begin
      busy = q.size() > 0;
      for (int i = 0; i < NREQ; i++) if (pv[i]) busy = 1'b1;
      if (busy) step();
    end
  endtask

  initial begin
    logic [3:0] rop;
    passed = 0;
    total  = 0;
    cyc    = 0;
    model_reset();

    // Reset held: no grants even with requests present, outputs cleared
    rst        = 1'b0;
    req_valid  = '1;
    req_opcode = '0;
    req_a      = '1;
    req_b      = '1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Single request
    set_req(0, OP_ADD, 8'd5, 8'd3);
    step();
    drain();

    // Contention: both requesters continuously valid
    repeat (6) begin
      if (!pv[0]) set_req(0, OP_SUB, 8'd10, 8'd4);
      if (!pv[1]) set_req(1, OP_AND, 8'd8, 8'd3);
      step();
    end
    drain();

    // Illegal opcode
    set_req(1, 4'b1111, 8'd7, 8'd9);
    step();
    drain();

    // Modulo wrap-around
    set_req(0, OP_SUB, 8'd3, 8'd5);
    step();
    set_req(0, OP_ADD, 8'd200, 8'd100);
    step();
    drain();

    // Reset while two operations are in flight
    set_req(0, OP_ADD, 8'd1, 8'd2);
    step();
    set_req(0, OP_SUB, 8'd9, 8'd1);
    step();
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    drive();
    req_valid = 2'b10;
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    cyc++;
    repeat (LAT + 3) step();
    set_req(0, OP_OR, 8'h50, 8'h0A);
    set_req(1, OP_XOR, 8'hFF, 8'h0F);
    step();
    drain();

    // Sustained throughput from one requester
    repeat (8) begin
      set_req(0, OP_XOR, 8'd6, 8'd2);
      step();
    end
    drain();

    // Random traffic, including illegal opcodes
    repeat (300) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(1, 0) == 1)) begin
          if ($urandom_range(3, 0) == 0) rop = 4'($urandom_range(15, 5));
          else                           rop = 4'($urandom_range(4, 0));
          set_req(i, rop, W'($urandom), W'($urandom));
        end
      end
      step();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
